// File: rtl/lcd_num_field_if.sv
// Purpose: request/response and LCD bus bundle between a controlling FSM and lcd_num_field_writer.
// Ports: start/value/row/col/blank_lz in from the controller; busy/done back to it;
//        data/rs/en/rw out to the HD44780-style LCD bus.
interface lcd_num_field_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             row;
  logic [3:0]       col;
  logic             blank_lz;
  logic             busy;
  logic             done;
  logic [7:0]       data;
  logic             rs;
  logic             en;
  logic             rw;

  modport master (
    output start, value, row, col, blank_lz,
    input  busy, done, data, rs, en, rw
  );

  modport slave (
    input  start, value, row, col, blank_lz,
    output busy, done, data, rs, en, rw
  );
endinterface

// File: rtl/lcd_num_field_writer.sv
// Purpose: converts a latched binary value to decimal (double-dabble, one bit per cycle) and writes a
//          fixed-width, optionally signed, optionally zero-blanked field to an HD44780 LCD at row/col.
// Ports:   clk, reset (sync, active-high); bus (slave modport): start/value/row/col/blank_lz in,
//          busy/done handshake out, data/rs/en/rw LCD bus out (rw tied 0).
// Timing:  busy is high for exactly WIDTH + (FIELD+1)*(SETUP_CYC+EN_CYC) cycles (constant term 0);
//          done pulses in the first cycle after the last en falls, and a new start is taken then.
module lcd_num_field_writer #(
  parameter int WIDTH     = 32,
  parameter int DIGITS    = 10,
  parameter int SIGNED    = 0,
  parameter int SETUP_CYC = 50000,
  parameter int EN_CYC    = 20
) (
  input logic            clk,
  input logic            reset,
  lcd_num_field_if.slave bus
);

  localparam int FIELD = DIGITS + SIGNED;
  // Decimal digits needed for 2^WIDTH-1; 0.30103 slightly over-estimates log10(2), so never short.
  localparam int NBCD  = (WIDTH * 30103) / 100000 + 1;
  localparam int NB    = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int CW    = $clog2(((SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC) + 1);
  localparam int BW    = $clog2(WIDTH + 1);
  localparam int IW    = $clog2(FIELD + 1);

  typedef enum logic [2:0] {
    IDLE, CONV, CMD_WAIT, CMD_EN, CHR_WAIT, CHR_EN, FIN
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mag, mag_in;
  logic [NB*4-1:0]   bcd, bcd_adj;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     cyc_cnt;
  logic [IW-1:0]     chr_idx;
  logic              row_q, blank_q, neg_q, neg_in;
  logic [3:0]        col_q;
  logic [7:0]        data_q, chr;
  logic              rs_q;
  logic              accept, conv_last, wait_last, en_last, chr_last;
  logic              ovf, zero_above, dig_blank;
  logic [DIGITS-1:0] lz;
  logic [3:0]        dig;
  int                d;

  assign accept    = bus.start && (state == IDLE || state == FIN);
  assign conv_last = (bit_cnt == BW'(WIDTH - 1));
  assign wait_last = (cyc_cnt == CW'(SETUP_CYC - 1));
  assign en_last   = (cyc_cnt == CW'(EN_CYC - 1));
  assign chr_last  = (chr_idx == IW'(FIELD - 1));

  // The WIDTH+1-bit negation of a negative value always has a zero top bit (|min| = 2^(WIDTH-1)),
  // so the low WIDTH bits hold the exact unsigned magnitude, including the most negative value.
  assign neg_in = (SIGNED != 0) && bus.value[WIDTH-1];
  assign mag_in = neg_in ? (~bus.value + WIDTH'(1)) : bus.value;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = CONV;
      CONV:     if (conv_last) state_nxt = CMD_WAIT;
      CMD_WAIT: if (wait_last) state_nxt = CMD_EN;
      CMD_EN:   if (en_last) state_nxt = CHR_WAIT;
      CHR_WAIT: if (wait_last) state_nxt = CHR_EN;
      CHR_EN:   if (en_last) state_nxt = chr_last ? FIN : CHR_WAIT;
      FIN:      state_nxt = accept ? CONV : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register; rs/data are held in registers between writes.
  assign bus.busy = (state != IDLE) && (state != FIN);
  assign bus.done = (state == FIN);
  assign bus.en   = (state == CMD_EN) || (state == CHR_EN);
  assign bus.rs   = rs_q;
  assign bus.data = data_q;
  assign bus.rw   = 1'b0;

  // Double-dabble: add 3 to every BCD digit >= 5 before each left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NB; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
  end

  // Character for the current field position.
  always_comb begin
    ovf = 1'b0;
    for (int i = DIGITS; i < NB; i++)
      if (bcd[i*4 +: 4] != 4'd0) ovf = 1'b1;
    // lz[i]: digit i and every digit above it (within the field) are zero.
    zero_above = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (bcd[i*4 +: 4] == 4'd0);
      lz[i] = zero_above;
    end
    d = DIGITS - 1 + SIGNED - int'(chr_idx);
    dig = 4'd0;
    dig_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (i == d) begin
        dig = bcd[i*4 +: 4];
        dig_blank = blank_q && lz[i] && (i != 0);
      end
    if (SIGNED != 0 && chr_idx == '0) chr = neg_q ? 8'h2D : 8'h20;
    else if (ovf)                     chr = 8'h2A;
    else if (dig_blank)               chr = 8'h20;
    else                              chr = {4'h3, dig};
  end

  // Datapath and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      mag <= '0; bcd <= '0; bit_cnt <= '0; cyc_cnt <= '0; chr_idx <= '0;
      row_q <= 1'b0; col_q <= 4'd0; blank_q <= 1'b0; neg_q <= 1'b0;
      rs_q <= 1'b0; data_q <= 8'h00;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (accept) begin
            mag <= mag_in; neg_q <= neg_in; bcd <= '0;
            row_q <= bus.row; col_q <= bus.col; blank_q <= bus.blank_lz;
            bit_cnt <= '0; cyc_cnt <= '0; chr_idx <= '0;
          end
        end
        CONV: begin
          bcd     <= {bcd_adj[NB*4-2:0], mag[WIDTH-1]};
          mag     <= mag << 1;
          bit_cnt <= bit_cnt + BW'(1);
        end
        CMD_WAIT, CHR_WAIT: begin
          cyc_cnt <= wait_last ? '0 : cyc_cnt + CW'(1);
          // rs/data change on the same edge en rises.
          if (wait_last) begin
            rs_q   <= (state == CHR_WAIT);
            data_q <= (state == CHR_WAIT) ? chr : {1'b1, row_q, 2'b00, col_q};
          end
        end
        CMD_EN, CHR_EN: begin
          cyc_cnt <= en_last ? '0 : cyc_cnt + CW'(1);
          if (state == CHR_EN && en_last) chr_idx <= chr_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_num_field_writer.sv
module tb_lcd_num_field_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  bit   sel;

  lcd_num_field_if #(.WIDTH(16)) if_a ();
  lcd_num_field_if #(.WIDTH(8))  if_b ();

  lcd_num_field_writer #(.WIDTH(16), .DIGITS(4), .SIGNED(0), .SETUP_CYC(4), .EN_CYC(2)) u_a (
    .clk(clk), .reset(rst_a), .bus(if_a)
  );
  lcd_num_field_writer #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .SETUP_CYC(4), .EN_CYC(2)) u_b (
    .clk(clk), .reset(rst_b), .bus(if_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Bus monitor on the selected DUT, sampled on the falling edge.
  logic [8:0] cap[$];
  int         hi_len[$];
  int         gap[$];
  int         done_cnt, busy_cyc, hi_run, lo_run;
  logic       en_prev;

  always @(negedge clk) begin
    logic en_n, rs_n, dn, bz;
    logic [7:0] d_n;
    en_n = sel ? if_b.en   : if_a.en;
    rs_n = sel ? if_b.rs   : if_a.rs;
    d_n  = sel ? if_b.data : if_a.data;
    dn   = sel ? if_b.done : if_a.done;
    bz   = sel ? if_b.busy : if_a.busy;
    if (en_n && !en_prev) begin
      cap.push_back({rs_n, d_n});
      gap.push_back(lo_run);
      hi_run = 1;
    end else if (en_n) hi_run++;
    if (!en_n && en_prev) begin
      hi_len.push_back(hi_run);
      lo_run = 1;
    end else if (!en_n) lo_run++;
    en_prev = en_n;
    if (dn) done_cnt++;
    if (bz) busy_cyc++;
  end

  task automatic drive(input bit s, input logic st, input logic [15:0] v, input logic r,
                       input logic [3:0] c, input logic b);
    if (!s) begin
      if_a.start = st; if_a.value = v; if_a.row = r; if_a.col = c; if_a.blank_lz = b;
    end else begin
      if_b.start = st; if_b.value = v[7:0]; if_b.row = r; if_b.col = c; if_b.blank_lz = b;
    end
  endtask

  task automatic clear_mon(input bit s);
    @(posedge clk);
    sel = s;
    cap.delete(); hi_len.delete(); gap.delete();
    done_cnt = 0; busy_cyc = 0; hi_run = 0; lo_run = 0; en_prev = 1'b0;
  endtask

  // One field write with bus-level checking; poke re-pulses start (value 99) mid-operation.
  task automatic run(input string tag, input bit s, input logic [15:0] v, input logic r,
                     input logic [3:0] c, input logic b, input logic [8:0] ex [5],
                     input int exp_busy, input bit poke);
    clear_mon(s);
    @(negedge clk); drive(s, 1'b1, v, r, c, b);
    @(negedge clk); drive(s, 1'b0, v, r, c, b);
    check({tag, "_busy_rise"}, s ? if_b.busy : if_a.busy, 1);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      @(negedge clk);
      if (poke && k == 10) drive(s, 1'b1, 16'd99, 1'b0, 4'd0, 1'b0);
      if (poke && k == 11) drive(s, 1'b0, 16'd99, 1'b0, 4'd0, 1'b0);
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_after"}, s ? if_b.busy : if_a.busy, 0);
    check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
    check({tag, "_writes"}, cap.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_wr%0d", tag, i), (i < cap.size()) ? cap[i] : 9'h1FF, ex[i]);
    check({tag, "_pulses"}, hi_len.size(), 5);
    for (int i = 0; i < hi_len.size(); i++)
      check($sformatf("%s_enhi%0d", tag, i), hi_len[i], 2);
    for (int i = 0; i < gap.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), gap[i] >= 4, 1);
  endtask

  initial begin
    sel = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    drive(1'b0, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", if_a.busy, 0);
    check("rst_done", if_a.done, 0);
    check("rst_en",   if_a.en,   0);
    check("rst_rs",   if_a.rs,   0);
    check("rst_data", if_a.data, 8'h00);
    check("rst_rw",   if_a.rw,   0);
    check("rst_b_en", if_b.en,   0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("idle_busy", if_a.busy, 0);

    run("a42_blz", 1'b0, 16'd42, 1'b1, 4'd2, 1'b1, '{9'h0C2, 9'h120, 9'h120, 9'h134, 9'h132}, 46, 1'b0);
    run("a42_lz",  1'b0, 16'd42, 1'b0, 4'd0, 1'b0, '{9'h080, 9'h130, 9'h130, 9'h134, 9'h132}, 46, 1'b0);
    run("a0",      1'b0, 16'd0,  1'b0, 4'd0, 1'b1, '{9'h080, 9'h120, 9'h120, 9'h120, 9'h130}, 46, 1'b0);
    run("a_ovf",   1'b0, 16'd12345, 1'b0, 4'd3, 1'b1, '{9'h083, 9'h12A, 9'h12A, 9'h12A, 9'h12A}, 46, 1'b0);
    run("b_m10",   1'b1, 16'h00F6, 1'b0, 4'd0, 1'b1, '{9'h080, 9'h12D, 9'h120, 9'h131, 9'h130}, 38, 1'b0);
    run("b_m128",  1'b1, 16'h0080, 1'b1, 4'd4, 1'b1, '{9'h0C4, 9'h12D, 9'h131, 9'h132, 9'h138}, 38, 1'b0);
    run("b_p5",    1'b1, 16'h0005, 1'b0, 4'd0, 1'b1, '{9'h080, 9'h120, 9'h120, 9'h120, 9'h135}, 38, 1'b0);
    run("b_p5lz",  1'b1, 16'h0005, 1'b0, 4'd0, 1'b0, '{9'h080, 9'h120, 9'h130, 9'h130, 9'h135}, 38, 1'b0);
    run("a_poke",  1'b0, 16'd42, 1'b1, 4'd2, 1'b1, '{9'h0C2, 9'h120, 9'h120, 9'h134, 9'h132}, 46, 1'b1);

    // Reset during the second character's en-high.
    clear_mon(1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 16'd42, 1'b1, 4'd2, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 16'd42, 1'b1, 4'd2, 1'b1);
    for (int k = 0; k < 400 && !(cap.size() == 3 && if_a.en); k++) @(negedge clk);
    check("mid_reached", (cap.size() == 3) && if_a.en, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_en",   if_a.en,   0);
    check("mid_rst_busy", if_a.busy, 0);
    check("mid_rst_rs",   if_a.rs,   0);
    check("mid_rst_data", if_a.data, 8'h00);
    rst_a = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_rst_nodone", done_cnt, 0);
    check("mid_rst_nowr",   cap.size(), 3);

    run("a7_after", 1'b0, 16'd7, 1'b1, 4'd15, 1'b0, '{9'h0CF, 9'h130, 9'h130, 9'h130, 9'h137}, 46, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_num_field_writer.md
Name: lcd_num_field_writer

Overview:
- Parametrised successor to the team's LCD number-display writer for the HD44780-style 16x2 LCD on the 8-bit bus.
- On a `start` strobe it latches a binary value and converts it to decimal with a sequential shift-add-3 (double-dabble) engine.
- It then writes a fixed-width, optionally signed, optionally zero-blanked decimal field at any row/column.
- Handshakes `busy`/`done` with the controlling FSM (keypad/calculator logic). Owns the LCD bus only while `busy`.

Parameters:
- WIDTH, 32, bit width of `value`.
- DIGITS, 10, decimal digit positions in the field (1..16).
- SIGNED, 0, 1 = `value` is two's complement and the field gets a leading sign character.
- SETUP_CYC, 50000, clk cycles with `en` low before each LCD write (>=2).
- EN_CYC, 20, clk cycles `en` is held high per write (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only when `busy`=0
- value  input  WIDTH  number to display; latched on accepted start
- row  input  1  0 = line 1 (DDRAM 0x00), 1 = line 2 (DDRAM 0x40); latched on start
- col  input  4  starting column 0..15; latched on start
- blank_lz  input  1  1 = leading zeros shown as space (0x20); latched on start
- busy  output  1  high while converting/writing
- done  output  1  one-cycle pulse when the field is complete
- data  output  8  LCD data bus
- rs  output  1  LCD register select (0 = command, 1 = character)
- en  output  1  LCD enable strobe
- rw  output  1  LCD read/write, constant 0

Behaviour:
- Reset values: data=0x00, rs=0, en=0, busy=0, done=0, FSM=IDLE, counters=0. `rw` is 0 at all times.
- Reset mid-operation: outputs return to reset values on the next edge. The partial field is abandoned and no `done` is issued.
- `reset` and `start` in the same cycle: reset wins.
- FSM states: IDLE -> CONV -> CMD_WAIT -> CMD_EN -> CHR_WAIT -> CHR_EN -> (CHR_WAIT | FIN) -> IDLE.
- IDLE:
  - On `start`, latch inputs, set busy=1 next cycle, go to CONV.
  - `start` while busy=1 is ignored (no re-latch, no effect).
- CONV:
  - If SIGNED=1 and value[WIDTH-1]=1: neg=1, magnitude = two's-complement negation computed in WIDTH+1 bits. This makes the most negative value correct, e.g. -128 for WIDTH=8.
  - Otherwise neg=0 and magnitude = value.
  - Double-dabble runs one bit per cycle, exactly WIDTH cycles. The internal BCD is sized for the full WIDTH range, independent of DIGITS.
- Overflow: if any BCD digit above position DIGITS-1 is nonzero, every digit character is '*' (0x2A). The sign character is unaffected.
- Field: FIELD = DIGITS + SIGNED characters, written left to right.
  - Sign character (SIGNED=1 only): '-' (0x2D) if neg, else space. It always occupies the first position.
  - Digit i character: 0x30 + BCD digit.
  - If blank_lz=1, each zero digit left of the most significant nonzero digit becomes 0x20.
  - The least significant digit is never blanked, so 0 displays as '0'.
  - Every write covers the whole field, so stale characters from a previous longer number are always overwritten.
- Write timing (identical for command and character writes):
  - *_WAIT: en=0 for SETUP_CYC cycles.
  - Then rs and data are driven in the same edge as en rises.
  - *_EN: en=1 for exactly EN_CYC cycles, then en falls.
  - rs and data hold their values until the next write's en-rise edge.
- Command write: rs=0, data = 0x80 | (row<<6) | col. Exactly one command per field.
- Column overflow: col+FIELD > 16 is not checked. The characters continue at LCD auto-increment addresses.
- FIN: busy=0 and done=1 for exactly one cycle, asserted the cycle after the last en falls. Then IDLE.
- A new start is accepted in the cycle done is high.
- Total busy cycles = WIDTH + (FIELD+1)*(SETUP_CYC+EN_CYC) + O(1). The exact constant is fixed by the implementation and documented in the RTL header.

Test Plan (WIDTH=16, DIGITS=4, SIGNED=0, SETUP_CYC=4, EN_CYC=2 unless stated):
- value=42, row=1, col=2, blank_lz=1 -> en pulses carry rs/data: 0/0xC2, 1/0x20, 1/0x20, 1/0x34, 1/0x32. Each en-high lasts exactly 2 cycles with >=4 low cycles between pulses. One done pulse follows; busy low afterwards.
- value=42, row=0, col=0, blank_lz=0 -> 0/0x80, then 0x30, 0x30, 0x34, 0x32.
- value=0, blank_lz=1 -> characters 0x20, 0x20, 0x20, 0x30. value=12345 -> 0x2A x4.
- SIGNED=1, WIDTH=8, DIGITS=3, blank_lz=1:
  - value=0xF6 (-10) -> 0x2D, 0x20, 0x31, 0x30.
  - value=0x80 -> 0x2D, 0x31, 0x32, 0x38.
  - value=0x05 -> 0x20, 0x20, 0x20, 0x35.
- start pulsed again while busy with value=99 -> ignored; the original field is completed unchanged. Reset asserted during a character en-high -> en=0, busy=0, rs=0, data=0x00 next cycle and no done pulse.
